// File: rtl/ttt_pkg.sv
// Shared codes and the winning-line table for the tic-tac-toe board reader.
package ttt_pkg;

    // Decoded (un-flipped) cell states
    localparam logic [1:0] CELL_EMPTY   = 2'b00;
    localparam logic [1:0] CELL_ILLEGAL = 2'b01;
    localparam logic [1:0] CELL_P2      = 2'b10;
    localparam logic [1:0] CELL_P1      = 2'b11;

    // Evaluation results
    localparam logic [1:0] RES_NOWIN = 2'b00;
    localparam logic [1:0] RES_TIE   = 2'b01;
    localparam logic [1:0] RES_P2    = 2'b10;
    localparam logic [1:0] RES_P1    = 2'b11;

    localparam logic [3:0] WINLINE_NONE = 4'hF;
    localparam logic [2:0] LAST_LINE    = 3'd7;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_SCAN = 2'd1,
        S_DONE = 2'd2
    } fsm_state_t;

    // Cell indices of each winning line: rows, columns, diagonals
    localparam logic [3:0] WIN_LINES [0:7][0:2] = '{
        '{4'd0, 4'd1, 4'd2},
        '{4'd3, 4'd4, 4'd5},
        '{4'd6, 4'd7, 4'd8},
        '{4'd0, 4'd3, 4'd6},
        '{4'd1, 4'd4, 4'd7},
        '{4'd2, 4'd5, 4'd8},
        '{4'd0, 4'd4, 4'd8},
        '{4'd2, 4'd4, 4'd6}
    };

    // A raw (flipped) board pair holds a player only as 11 or 01; 10 is illegal
    function automatic logic pair_filled(input logic [1:0] pair);
        return (pair == 2'b11) || (pair == 2'b01);
    endfunction

endpackage

// File: rtl/board_reader_cell_decode.sv
// Un-flips one stored board pair into a cellState; the illegal code reads as empty.
module cell_decode
    import ttt_pkg::*;
(
    input  logic [1:0] pair,
    output logic [1:0] state
);

    logic [1:0] raw;

    // Swap the bit order, then squash the illegal code to empty
    always_comb begin
        raw   = {pair[0], pair[1]};
        state = (raw == CELL_ILLEGAL) ? CELL_EMPTY : raw;
    end

endmodule

// File: rtl/board_reader.sv
// Board read port plus a one-line-per-clock win/tie evaluator with
// start/done/ack handshake toward the game controller.
module board_reader
    import ttt_pkg::*;
#(
    parameter int N_CELLS = 9,
    parameter int CELL_W  = 2
) (
    input  logic                        ph1,
    input  logic                        reset,
    input  logic [N_CELLS*CELL_W-1:0]   gameBoard,
    input  logic [3:0]                  rdAddr,
    output logic [1:0]                  rdState,
    input  logic                        start,
    output logic                        busy,
    output logic                        done,
    input  logic                        ack,
    output logic [1:0]                  result,
    output logic [3:0]                  winLine
);

    if (N_CELLS != 9 || CELL_W != 2) begin : g_bad_geometry
        $error("board_reader supports only a 9-cell board of 2-bit cells");
    end

    fsm_state_t                  state;
    logic [N_CELLS*CELL_W-1:0]   snapshot;
    logic [2:0]                  lineIdx;

    // ---------------- read port ----------------
    logic [1:0] rd_pair;
    logic [1:0] rd_dec;

    // Pick the raw pair for rdAddr; out-of-board addresses read as empty
    always_comb begin
        rd_pair = 2'b00;
        if (rdAddr < 4'd9)
            rd_pair = gameBoard[{rdAddr, 1'b0} +: 2];
    end

    cell_decode u_rd_dec (
        .pair  (rd_pair),
        .state (rd_dec)
    );

    // Registered read, independent of the evaluator
    always_ff @(posedge ph1 or negedge reset) begin
        if (!reset) rdState <= CELL_EMPTY;
        else        rdState <= rd_dec;
    end

    // ---------------- line evaluation ----------------
    logic [2:0][1:0] line_pair;
    logic [2:0][1:0] line_cell;
    logic            line_win;
    logic            all_filled;

    for (genvar j = 0; j < 3; j++) begin : g_line
        // Fetch cell j of the current line from the snapshot
        always_comb begin
            line_pair[j] = snapshot[{WIN_LINES[lineIdx][j], 1'b0} +: 2];
        end

        cell_decode u_ln_dec (
            .pair  (line_pair[j]),
            .state (line_cell[j])
        );
    end

    // Win when all three decoded cells match and are occupied
    always_comb begin
        line_win = (line_cell[0] != CELL_EMPTY) &&
                   (line_cell[0] == line_cell[1]) &&
                   (line_cell[1] == line_cell[2]);
    end

    // Tie needs every cell occupied by a legal player code
    always_comb begin
        all_filled = 1'b1;
        for (int i = 0; i < N_CELLS; i++)
            if (!pair_filled(snapshot[2*i +: 2]))
                all_filled = 1'b0;
    end

    // Handshake FSM: snapshot on start, scan 8 lines, hold result until ack
    always_ff @(posedge ph1 or negedge reset) begin
        if (!reset) begin
            state    <= S_IDLE;
            snapshot <= '0;
            lineIdx  <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            result   <= RES_NOWIN;
            winLine  <= WINLINE_NONE;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        snapshot <= gameBoard;
                        lineIdx  <= '0;
                        busy     <= 1'b1;
                        state    <= S_SCAN;
                    end
                end
                S_SCAN: begin
                    if (line_win) begin
                        // Cell codes for the players equal their result codes
                        result  <= line_cell[0];
                        winLine <= {1'b0, lineIdx};
                        busy    <= 1'b0;
                        done    <= 1'b1;
                        state   <= S_DONE;
                    end else if (lineIdx != LAST_LINE) begin
                        lineIdx <= lineIdx + 3'd1;
                    end else begin
                        result  <= all_filled ? RES_TIE : RES_NOWIN;
                        winLine <= WINLINE_NONE;
                        busy    <= 1'b0;
                        done    <= 1'b1;
                        state   <= S_DONE;
                    end
                end
                S_DONE: begin
                    if (ack) begin
                        done  <= 1'b0;
                        state <= S_IDLE;
                    end
                end
                default: begin
                    busy  <= 1'b0;
                    done  <= 1'b0;
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_board_reader.sv
// Scoreboard bench for board_reader: stimulus queues expected results,
// monitors pop and compare whenever done rises or a read completes.
module tb_board_reader;

    logic        ph1 = 1'b0;
    logic        reset;
    logic [17:0] gameBoard;
    logic [3:0]  rdAddr;
    logic [1:0]  rdState;
    logic        start, ack;
    logic        busy, done;
    logic [1:0]  result;
    logic [3:0]  winLine;

    typedef struct {
        logic [1:0] res;
        logic [3:0] wl;
        int         cyc;
    } exp_t;

    exp_t       exp_q[$];
    logic [1:0] rd_q[$];
    int         cyc    = 0;
    int         checks = 0;
    int         errors = 0;

    board_reader #(.N_CELLS(9), .CELL_W(2)) dut (
        .ph1       (ph1),
        .reset     (reset),
        .gameBoard (gameBoard),
        .rdAddr    (rdAddr),
        .rdState   (rdState),
        .start     (start),
        .busy      (busy),
        .done      (done),
        .ack       (ack),
        .result    (result),
        .winLine   (winLine)
    );

    always #5 ph1 = ~ph1;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Edge counter used for latency checks
    initial forever begin
        @(posedge ph1);
        cyc++;
    end

    // Evaluation monitor: compare on each rising edge of done
    initial begin
        logic done_prev;
        exp_t e;
        done_prev = 1'b0;
        forever begin
            @(posedge ph1);
            #1;
            if (done && !done_prev) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_done", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    chk("result", result, e.res);
                    chk("winLine", winLine, e.wl);
                    chk("latency", cyc, e.cyc);
                    chk("busy_in_done", busy, 0);
                end
            end
            done_prev = done;
        end
    end

    // Read-port monitor: one expected value per issued address
    initial forever begin
        @(posedge ph1);
        #1;
        if (rd_q.size() != 0) chk("rdState", rdState, rd_q.pop_front());
    end

    task automatic wait_done();
        int n = 0;
        while (!done && n < 30) begin
            @(negedge ph1);
            n++;
        end
        if (!done) chk("done_timeout", 0, 1);
    endtask

    task automatic do_ack();
        @(negedge ph1); ack = 1'b1;
        @(negedge ph1); ack = 1'b0;
        chk("done_after_ack", done, 0);
    endtask

    // lat = edges after E0 until done is visible
    task automatic run_eval(input logic [17:0] b, input logic [1:0] r,
                            input logic [3:0] w, input int lat);
        exp_t e;
        @(negedge ph1);
        gameBoard = b;
        start     = 1'b1;
        e.res = r; e.wl = w; e.cyc = cyc + 1 + lat;
        exp_q.push_back(e);
        @(negedge ph1);
        start = 1'b0;
        chk("busy_in_scan", busy, 1);
        wait_done();
        do_ack();
    endtask

    localparam logic [17:0] B_TIE     = 18'h37D5F;
    localparam logic [17:0] B_TIE_ILL = 18'h37E5F;

    initial begin
        logic [1:0] rd_exp [0:15];
        exp_t e;
        rd_exp = '{2'b11, 2'b11, 2'b10, 2'b10, 2'b00, 2'b11, 2'b11, 2'b10,
                   2'b11, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00};

        reset = 1'b0; gameBoard = '0; rdAddr = 4'd0; start = 1'b0; ack = 1'b0;
        repeat (2) @(negedge ph1);
        chk("rst_rdState", rdState, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_result", result, 0);
        chk("rst_winLine", winLine, 4'hF);
        reset = 1'b1;

        // Empty board, P1 row 0, P2 anti-diagonal, tie, illegal centre
        run_eval(18'h00000, 2'b00, 4'hF, 8);
        run_eval(18'h0003F, 2'b11, 4'd0, 1);
        run_eval(18'h01110, 2'b10, 4'd7, 8);
        run_eval(B_TIE,     2'b01, 4'hF, 8);
        run_eval(B_TIE_ILL, 2'b00, 4'hF, 8);
        // Double win (lines 3 and 6) reports line 3; illegal row never wins
        run_eval(18'h333C3, 2'b11, 4'd3, 4);
        run_eval(18'h0002A, 2'b00, 4'hF, 8);

        // Board change and start during SCAN must not disturb the snapshot
        @(negedge ph1);
        gameBoard = 18'h01110; start = 1'b1;
        e.res = 2'b10; e.wl = 4'd7; e.cyc = cyc + 9;
        exp_q.push_back(e);
        @(negedge ph1); start = 1'b0; gameBoard = 18'h0003F;
        @(negedge ph1); start = 1'b1;
        @(negedge ph1); start = 1'b0;
        wait_done();
        // start during DONE is ignored; outputs hold
        for (int i = 0; i < 3; i++) begin
            @(negedge ph1);
            gameBoard = B_TIE; start = 1'b1;
            chk("done_hold", done, 1);
            chk("result_hold", result, 2'b10);
            chk("winLine_hold", winLine, 4'd7);
        end
        // start and ack together: back to IDLE, no new scan
        @(negedge ph1); start = 1'b1; ack = 1'b1;
        @(negedge ph1); start = 1'b0; ack = 1'b0;
        chk("ack_start_done", done, 0);
        chk("ack_start_busy", busy, 0);
        @(negedge ph1);
        chk("no_rescan_busy", busy, 0);
        chk("result_after_ack", result, 2'b10);

        // Read sweep over all addresses
        gameBoard = B_TIE_ILL;
        for (int a = 0; a < 16; a++) begin
            @(negedge ph1);
            rdAddr = a[3:0];
            rd_q.push_back(rd_exp[a]);
        end
        @(negedge ph1);

        // Reset in the middle of a scan
        gameBoard = 18'h00000; start = 1'b1;
        @(negedge ph1); start = 1'b0;
        @(negedge ph1);
        chk("busy_before_rst", busy, 1);
        reset = 1'b0;
        #1;
        chk("midrst_busy", busy, 0);
        chk("midrst_done", done, 0);
        chk("midrst_winLine", winLine, 4'hF);
        chk("midrst_result", result, 0);
        @(negedge ph1); reset = 1'b1;
        repeat (12) @(negedge ph1);
        chk("midrst_no_done", done, 0);

        chk("exp_q_drained", exp_q.size(), 0);
        chk("rd_q_drained", rd_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
